dtree_walker: RTL and testbench
===============================

Name: dtree_walker

Overview:
Programmable, sequential successor to the team's fixed combinational decision-tree classifiers. A node table is loaded through a config port; each accepted feature vector is walked from the root, one node per clock, until a leaf yields a class. Sits between the feature-extraction stage and the class-vote/aggregation logic, with valid/ready handshakes on both sides. Node-table size, feature count, class width and depth limit are parametrised.

Parameters:
N_FEATURES, 51, width of the binary feature vector
N_NODES, 64, node-table entries; root is entry 0
CLS_W, 2, class code width
MAX_DEPTH, 16, maximum internal nodes traversed before abort
(derived) FIDX_W = $clog2(N_FEATURES), NODE_W = $clog2(N_NODES), DEPTH_W = $clog2(MAX_DEPTH+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  node-table write strobe
cfg_addr  in  NODE_W  entry written
cfg_leaf  in  1  1 = leaf entry
cfg_fidx  in  FIDX_W  feature index tested (internal node)
cfg_lo  in  NODE_W  child taken when the tested bit is 0
cfg_hi  in  NODE_W  child taken when the tested bit is 1
cfg_class  in  CLS_W  class code (leaf entry)
cfg_busy  out  1  high when not IDLE; writes are ignored while high
in_valid  in  1  feature vector valid
in_ready  out  1  high only in IDLE
in_feat  in  N_FEATURES  feature vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_class  out  CLS_W  class result
out_err  out  1  walk aborted (depth exceeded or bad index)
out_depth  out  DEPTH_W  internal nodes traversed

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; all node entries cleared to zero, so entry 0 is a leaf of class 0. out_valid=0, out_class=0, out_err=0, out_depth=0, cfg_busy=0, in_ready=1 after reset is released.
- Config: cfg_we is honoured only in IDLE, and the entry is written on that edge. cfg_addr >= N_NODES is ignored. A write in the same cycle as an input handshake takes effect before the walk reads the table.
- States: IDLE, WALK, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_feat, ptr=0, depth=0, go to WALK.
- WALK: read entry[ptr] combinationally.
  - If leaf: out_class=entry class, out_err=0, out_depth=depth, go to DONE.
  - Else, error case: if fidx >= N_FEATURES, or the selected child >= N_NODES, or depth==MAX_DEPTH: out_class=0, out_err=1, out_depth=depth, go to DONE.
  - Otherwise: ptr = feat[fidx] ? hi : lo, and depth increments.
- DONE: out_valid=1. out_class, out_err and out_depth stay stable until out_ready. On out_valid&&out_ready: clear out_valid and go to IDLE. in_ready stays 0 in DONE, so there is no accept in the handshake cycle.
- Latency: a leaf reached after d internal nodes gives out_valid high d+2 edges after the input handshake edge. Throughput is one vector per walk.
- Loops in the table are bounded by MAX_DEPTH and report out_err=1.
- in_feat changes after acceptance have no effect.
- Reset asserted mid-walk or while in DONE: immediate return to reset values. The node table is also cleared.

Test Plan:
- Reset, no config; input any vector -> out_valid 2 cycles after accept, out_class=0, out_depth=0, out_err=0.
- Program node0 = {fidx=4, lo=1, hi=2}, node1 = leaf class 1, node2 = leaf class 3.
  - in_feat[4]=1 -> out_class=3, out_depth=1, out_valid 3 cycles after accept.
  - in_feat[4]=0 -> out_class=1.
- Chain the 51-feature mapping from i[37]/i[49]/i[36] down to leaves of depth 6 -> out_class matches the golden model for 1000 random vectors, out_depth=6.
- Self-loop: node0 = {fidx=0, lo=0, hi=0} -> out_err=1, out_class=0, out_depth=16 after 18 cycles.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. A cfg_we pulse while busy leaves the table unchanged, checked by re-running the vector.
- Assert rst_n=0 mid-walk -> out_valid=0 immediately; the next input yields class 0 (table cleared).

Source files
------------

// File: rtl/dtree_walker.sv
// Sequential decision-tree classifier: a programmable node table is walked from
// entry 0, one node per clock, until a leaf yields a class or the walk aborts.
module dtree_walker #(
  parameter  int N_FEATURES = 51,
  parameter  int N_NODES    = 64,
  parameter  int CLS_W      = 2,
  parameter  int MAX_DEPTH  = 16,
  localparam int FIDX_W     = $clog2(N_FEATURES),
  localparam int NODE_W     = $clog2(N_NODES),
  localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [NODE_W-1:0]     cfg_addr,
  input  logic                  cfg_leaf,
  input  logic [FIDX_W-1:0]     cfg_fidx,
  input  logic [NODE_W-1:0]     cfg_lo,
  input  logic [NODE_W-1:0]     cfg_hi,
  input  logic [CLS_W-1:0]      cfg_class,
  output logic                  cfg_busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_FEATURES-1:0] in_feat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CLS_W-1:0]      out_class,
  output logic                  out_err,
  output logic [DEPTH_W-1:0]    out_depth
);

  typedef struct packed {
    logic              leaf;
    logic [FIDX_W-1:0] fidx;
    logic [NODE_W-1:0] lo;
    logic [NODE_W-1:0] hi;
    logic [CLS_W-1:0]  cls;
  } node_t;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

  state_e                state_q;
  node_t                 table_q [N_NODES];
  logic [N_FEATURES-1:0] feat_q;
  logic [NODE_W-1:0]     ptr_q;
  logic [DEPTH_W-1:0]    depth_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic [CLS_W-1:0]      out_class_q;
  logic                  out_err_q;
  logic [DEPTH_W-1:0]    out_depth_q;

  node_t                 cur;
  logic                  fidx_ok;
  logic                  tested_bit;
  logic [NODE_W-1:0]     child;
  logic                  walk_err;

  // NOTE: the table is a register file with async reset because a reset must
  // leave entry 0 as a class-0 leaf; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) table_q[i] <= '0;
    end else if (cfg_we && state_q == IDLE && 32'(cfg_addr) < N_NODES) begin
      // NOTE: non-blocking so every sequential block sees pre-edge values.
      table_q[cfg_addr] <= '{leaf: cfg_leaf, fidx: cfg_fidx, lo: cfg_lo,
                             hi: cfg_hi, cls: cfg_class};
    end
  end

  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    cur        = '0;
    if (32'(ptr_q) < N_NODES) cur = table_q[ptr_q];
    fidx_ok    = 32'(cur.fidx) < N_FEATURES;
    tested_bit = fidx_ok ? feat_q[cur.fidx] : 1'b0;
    child      = tested_bit ? cur.hi : cur.lo;
    walk_err   = !fidx_ok || (32'(child) >= N_NODES) ||
                 (depth_q == DEPTH_W'(MAX_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      feat_q      <= '0;
      ptr_q       <= '0;
      depth_q     <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
      out_depth_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            feat_q     <= in_feat;
            ptr_q      <= '0;
            depth_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= WALK;
          end
        end
        WALK: begin
          if (cur.leaf) begin
            out_class_q <= cur.cls;
            out_err_q   <= 1'b0;
            out_depth_q <= depth_q;
            state_q     <= DONE;
          end else if (walk_err) begin
            out_class_q <= '0;
            out_err_q   <= 1'b1;
            out_depth_q <= depth_q;
            state_q     <= DONE;
          end else begin
            ptr_q   <= child;
            depth_q <= depth_q + DEPTH_W'(1);
          end
        end
        DONE: begin
          // Result is captured on entry; valid rises on the following edge.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_busy  = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_err   = out_err_q;
  assign out_depth = out_depth_q;

endmodule

// File: tb/tb_dtree_walker.sv
// Bench for dtree_walker: a behavioural walk over a bench-side copy of the node
// table pushes expected results into a queue that is popped on each DUT result.
module tb_dtree_walker;

  localparam int NF = 51;
  localparam int NN = 64;
  localparam int CW = 2;
  localparam int MD = 16;
  localparam int FW = $clog2(NF);
  localparam int NW = $clog2(NN);
  localparam int DW = $clog2(MD + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [NW-1:0] cfg_addr = '0;
  logic          cfg_leaf = 1'b0;
  logic [FW-1:0] cfg_fidx = '0;
  logic [NW-1:0] cfg_lo = '0;
  logic [NW-1:0] cfg_hi = '0;
  logic [CW-1:0] cfg_class = '0;
  logic          cfg_busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NF-1:0] in_feat = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_class;
  logic          out_err;
  logic [DW-1:0] out_depth;

  dtree_walker #(.N_FEATURES(NF), .N_NODES(NN), .CLS_W(CW), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_leaf(cfg_leaf), .cfg_fidx(cfg_fidx),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_class(cfg_class), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .out_depth(out_depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit leaf;
    int fidx;
    int lo;
    int hi;
    int cls;
  } mnode_t;

  typedef struct {
    int cls;
    bit err;
    int depth;
    int lat;
  } exp_t;

  mnode_t mdl [NN];
  exp_t   exp_q [$];
  int     n_cmp = 0;
  int     n_mis = 0;

  function automatic logic [NF-1:0] rand_feat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NF-1:0];
  endfunction

  // Behavioural walk; the result appears two edges after the last node visited.
  function automatic exp_t model_walk(input logic [NF-1:0] f);
    exp_t e;
    int   ptr;
    int   d;
    int   nxt;
    bit   done;
    e.cls = 0; e.err = 1'b0; e.depth = 0; e.lat = 0;
    ptr = 0; d = 0; done = 1'b0;
    while (!done) begin
      if (mdl[ptr].leaf) begin
        e.cls = mdl[ptr].cls; e.err = 1'b0; done = 1'b1;
      end else if (mdl[ptr].fidx >= NF || d == MD) begin
        e.cls = 0; e.err = 1'b1; done = 1'b1;
      end else begin
        nxt = f[mdl[ptr].fidx] ? mdl[ptr].hi : mdl[ptr].lo;
        if (nxt >= NN) begin
          e.cls = 0; e.err = 1'b1; done = 1'b1;
        end else begin
          ptr = nxt; d++;
        end
      end
    end
    e.depth = d;
    e.lat   = d + 2;
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NN; i++) mdl[i] = '{leaf: 1'b0, fidx: 0, lo: 0, hi: 0, cls: 0};
  endtask

  task automatic set_cfg(input int addr, input bit leaf, input int fidx, input int lo,
                         input int hi, input int cls);
    cfg_addr  = NW'(addr);
    cfg_leaf  = leaf;
    cfg_fidx  = FW'(fidx);
    cfg_lo    = NW'(lo);
    cfg_hi    = NW'(hi);
    cfg_class = CW'(cls);
  endtask

  task automatic cfg_write(input int addr, input bit leaf, input int fidx, input int lo,
                           input int hi, input int cls);
    set_cfg(addr, leaf, fidx, lo, hi, cls);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mdl[addr] = '{leaf: leaf, fidx: fidx, lo: lo, hi: hi, cls: cls};
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_model();
  endtask

  // cfg_mode: 0 none, 1 cfg_we with the handshake (caller updates mdl first),
  // 2 cfg_we pulse during the walk (must be ignored).
  task automatic send_vec(input logic [NF-1:0] f, input int hold, input int cfg_mode,
                          input string tag);
    exp_t          e;
    int            w;
    int            cyc;
    logic [CW-1:0] cls_s;
    logic          err_s;
    logic [DW-1:0] dep_s;
    exp_q.push_back(model_walk(f));
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_mis++; $display("FAIL %s in_ready_wait: got %b want 1", tag, in_ready);
    end
    in_feat = f; in_valid = 1'b1;
    if (cfg_mode == 1) cfg_we = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    in_feat = rand_feat();
    if (cfg_mode == 2) begin
      cfg_we = 1'b1;
      n_cmp++;
      if (cfg_busy !== 1'b1) begin
        n_mis++; $display("FAIL %s cfg_busy: got %b want 1", tag, cfg_busy);
      end
    end
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      cfg_we = 1'b0;
      in_feat = rand_feat();
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (cyc != e.lat || out_valid !== 1'b1) begin
      n_mis++; $display("FAIL %s latency: got %0d (valid=%b) want %0d", tag, cyc, out_valid, e.lat);
    end
    n_cmp++;
    if (out_class !== CW'(e.cls)) begin
      n_mis++; $display("FAIL %s out_class: got %0d want %0d", tag, out_class, e.cls);
    end
    n_cmp++;
    if (out_err !== e.err) begin
      n_mis++; $display("FAIL %s out_err: got %b want %b", tag, out_err, e.err);
    end
    n_cmp++;
    if (out_depth !== DW'(e.depth)) begin
      n_mis++; $display("FAIL %s out_depth: got %0d want %0d", tag, out_depth, e.depth);
    end
    cls_s = CW'(e.cls); err_s = e.err; dep_s = DW'(e.depth);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== cls_s ||
          out_err !== err_s || out_depth !== dep_s) begin
        n_mis++;
        $display("FAIL %s hold%0d: got v=%b rdy=%b c=%0d e=%b d=%0d want v=1 rdy=0 c=%0d e=%b d=%0d",
                 tag, i, out_valid, in_ready, out_class, out_err, out_depth, cls_s, err_s, dep_s);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s release: got v=%b rdy=%b busy=%b want 0 1 0", tag, out_valid, in_ready, cfg_busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_busy !== 1'b0 ||
        out_class !== '0 || out_err !== 1'b0 || out_depth !== '0) begin
      n_mis++;
      $display("FAIL reset_state: got v=%b rdy=%b busy=%b c=%0d e=%b d=%0d want 0 1 0 0 0 0",
               out_valid, in_ready, cfg_busy, out_class, out_err, out_depth);
    end
    send_vec(rand_feat(), 0, 0, "reset_leaf");
  endtask

  task automatic test_small_tree();
    logic [NF-1:0] f;
    cfg_write(0, 1'b0, 4, 1, 2, 0);
    cfg_write(1, 1'b1, 0, 0, 0, 1);
    cfg_write(2, 1'b1, 0, 0, 0, 3);
    f = rand_feat(); f[4] = 1'b1;
    send_vec(f, 0, 0, "small_hi");
    f = rand_feat(); f[4] = 1'b0;
    send_vec(f, 0, 0, "small_lo");
  endtask

  task automatic test_chain();
    int lvl_f [1:5][2];
    lvl_f[1] = '{49, 36}; lvl_f[2] = '{36, 5}; lvl_f[3] = '{11, 44};
    lvl_f[4] = '{28, 0};  lvl_f[5] = '{50, 17};
    cfg_write(0, 1'b0, 37, 1, 2, 0);
    for (int l = 1; l <= 4; l++) begin
      cfg_write(2*l - 1, 1'b0, lvl_f[l][0], 2*l + 1, 2*l + 2, 0);
      cfg_write(2*l,     1'b0, lvl_f[l][1], 2*l + 2, 2*l + 1, 0);
    end
    cfg_write(9,  1'b0, lvl_f[5][0], 11, 12, 0);
    cfg_write(10, 1'b0, lvl_f[5][1], 14, 13, 0);
    for (int k = 0; k < 4; k++) cfg_write(11 + k, 1'b1, 0, 0, 0, k);
    for (int n = 0; n < 1000; n++) send_vec(rand_feat(), 0, 0, "chain");
  endtask

  task automatic test_errors();
    cfg_write(0, 1'b0, 0, 0, 0, 0);
    send_vec(rand_feat(), 0, 0, "self_loop");
    cfg_write(0, 1'b0, 55, 1, 2, 0);
    send_vec(rand_feat(), 0, 0, "bad_fidx");
  endtask

  task automatic test_hold_and_busy_cfg();
    logic [NF-1:0] f;
    cfg_write(0, 1'b0, 4, 1, 2, 0);
    f = rand_feat(); f[4] = 1'b1;
    set_cfg(2, 1'b1, 0, 0, 0, 0);
    send_vec(f, 5, 2, "hold_busy");
    send_vec(f, 0, 0, "busy_rerun");
  endtask

  task automatic test_same_cycle_cfg();
    set_cfg(0, 1'b1, 0, 0, 0, 2);
    mdl[0] = '{leaf: 1'b1, fidx: 0, lo: 0, hi: 0, cls: 2};
    send_vec(rand_feat(), 0, 1, "same_cycle_cfg");
  endtask

  task automatic test_back_to_back();
    cfg_write(0, 1'b0, 7, 1, 2, 0);
    cfg_write(1, 1'b1, 0, 0, 0, 1);
    cfg_write(2, 1'b0, 8, 3, 4, 0);
    cfg_write(3, 1'b1, 0, 0, 0, 2);
    cfg_write(4, 1'b1, 0, 0, 0, 3);
    for (int n = 0; n < 8; n++) send_vec(rand_feat(), 0, 0, "back_to_back");
  endtask

  task automatic test_reset_midwalk();
    cfg_write(0, 1'b0, 0, 0, 0, 0);
    in_feat = rand_feat(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || cfg_busy !== 1'b0) begin
      n_mis++; $display("FAIL midwalk_reset: got v=%b busy=%b want 0 0", out_valid, cfg_busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_model();
    send_vec(rand_feat(), 0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_small_tree();
    test_chain();
    test_errors();
    test_hold_and_busy_cfg();
    test_same_cycle_cfg();
    test_back_to_back();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
